// File: rtl/sng_sched_pkg.sv
// Shared types and helpers for the stochastic-number generator scheduler.
package sng_sched_pkg;

  localparam int NUM_BIT_DEF = 8;
  localparam int MAX_LEN     = 2**NUM_BIT_DEF - 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    RUN   = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  // A programmed length of zero selects the longest stream the counter supports.
  function automatic logic [31:0] len_eff(input logic [31:0] len, input int num_bit);
    logic [31:0] max_len;
    max_len = (32'd1 << num_bit) - 32'd1;
    return (len == 32'd0) ? max_len : len;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin search: first asserted request at or after ptr, wrapping.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int REQ_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [REQ_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [REQ_W-1:0]   idx,
  output logic               valid
);

  int               pos;
  logic [REQ_W-1:0] pos_w;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    pos   = 0;
    pos_w = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      pos = int'(ptr) + i;
      if (pos >= NUM_REQ) pos = pos - NUM_REQ;
      pos_w = REQ_W'(pos);
      if (!valid && req[pos_w]) begin
        valid      = 1'b1;
        gnt[pos_w] = 1'b1;
        idx        = pos_w;
      end
    end
  end

endmodule

// File: rtl/sng_scheduler.sv
// Round-robin sharing of one SN generator among NUM_REQ PE groups.
// Optional build macro SNG_SCHED_PERF_EN adds busy-cycle and abort counters.
module sng_scheduler
  import sng_sched_pkg::*;
#(
  parameter int NUM_BIT = 8,
  parameter int DIM     = 3,
  parameter int NUM_REQ = 4,
  parameter int REQ_W   = $clog2(NUM_REQ)
) (
  input  logic                                    i_clk_sng_sched,
  input  logic                                    i_rst_sng_sched,
  input  logic [NUM_REQ-1:0]                      i_req,
  input  logic [NUM_REQ-1:0][DIM-1:0][NUM_BIT-1:0] i_x_bn,
  input  logic [NUM_BIT-1:0]                      i_len,
  input  logic                                    i_abort,
  output logic [NUM_REQ-1:0]                      o_gnt,
  output logic [REQ_W-1:0]                        o_owner,
  output logic                                    o_busy,
  output logic [DIM-1:0][NUM_BIT-1:0]             o_x_bn,
  output logic                                    o_start,
  output logic                                    o_stop,
  input  logic                                    i_isgen,
  output logic [NUM_REQ-1:0]                      o_done,
  output logic                                    o_aborted,
`ifdef SNG_SCHED_PERF_EN
  output logic [31:0]                             o_perf_busy,
  output logic [15:0]                             o_perf_abort,
`endif
  output state_t                                  o_state
);

  // Handshake: i_req[k] is a level held until the one-cycle o_gnt[k] pulse, which
  // also marks the cycle its operands and i_len were captured; o_done[k] closes it.
  state_t                   state, state_n;
  logic   [REQ_W-1:0]       rr_ptr, ptr_inc;
  logic   [NUM_BIT-1:0]     cnt, len_r, len_m1;
  logic                     aborted_r, terminal, abort_take;
  logic   [NUM_REQ-1:0]     arb_gnt;
  logic   [REQ_W-1:0]       arb_idx;
  logic                     arb_valid;
  logic   [NUM_REQ-1:0]     gnt_d, done_d;
  logic                     start_d, stop_d, aborted_d;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .REQ_W(REQ_W)) u_arb (
    .req   (i_req),
    .ptr   (rr_ptr),
    .gnt   (arb_gnt),
    .idx   (arb_idx),
    .valid (arb_valid)
  );

  assign len_m1     = NUM_BIT'(len_eff(32'(len_r), NUM_BIT) - 32'd1);
  assign terminal   = (cnt == len_m1);
  // Terminal count wins over a simultaneous abort.
  assign abort_take = i_abort && ((state == START) || (state == RUN && !terminal));
  assign ptr_inc    = (arb_idx == REQ_W'(NUM_REQ - 1)) ? '0 : arb_idx + REQ_W'(1);
  assign o_busy     = (state != IDLE);
  assign o_state    = state;

  always_ff @(posedge i_clk_sng_sched or posedge i_rst_sng_sched) begin
    if (i_rst_sng_sched) state <= IDLE;
    else                 state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (arb_valid) state_n = START;
      START:   state_n = i_abort ? DRAIN : RUN;
      RUN:     if (terminal || i_abort) state_n = DRAIN;
      DRAIN:   if (!i_isgen) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    gnt_d     = '0;
    done_d    = '0;
    start_d   = 1'b0;
    stop_d    = 1'b0;
    aborted_d = 1'b0;
    unique case (state)
      IDLE:  if (arb_valid) gnt_d = arb_gnt;
      START: begin
        start_d = !i_abort;
        stop_d  = i_abort;
      end
      RUN:   stop_d = terminal || i_abort;
      DRAIN: if (!i_isgen) begin
        done_d[o_owner] = 1'b1;
        aborted_d       = aborted_r;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk_sng_sched or posedge i_rst_sng_sched) begin
    if (i_rst_sng_sched) begin
      rr_ptr    <= '0;
      o_owner   <= '0;
      o_x_bn    <= '0;
      len_r     <= '0;
      cnt       <= '0;
      aborted_r <= 1'b0;
      o_gnt     <= '0;
      o_start   <= 1'b0;
      o_stop    <= 1'b0;
      o_done    <= '0;
      o_aborted <= 1'b0;
    end else begin
      o_gnt     <= gnt_d;
      o_start   <= start_d;
      o_stop    <= stop_d;
      o_done    <= done_d;
      o_aborted <= aborted_d;
      if (state == IDLE && arb_valid) begin
        o_x_bn  <= i_x_bn[arb_idx];
        len_r   <= i_len;
        o_owner <= arb_idx;
        rr_ptr  <= ptr_inc;
      end
      if (state == START)                     cnt <= '0;
      else if (state == RUN && state_n == RUN) cnt <= cnt + NUM_BIT'(1);
      if (abort_take)         aborted_r <= 1'b1;
      else if (state == DONE) aborted_r <= 1'b0;
    end
  end

`ifdef SNG_SCHED_PERF_EN
  always_ff @(posedge i_clk_sng_sched or posedge i_rst_sng_sched) begin
    if (i_rst_sng_sched) begin
      o_perf_busy  <= '0;
      o_perf_abort <= '0;
    end else begin
      if (o_busy && o_perf_busy != '1)     o_perf_busy  <= o_perf_busy + 32'd1;
      if (aborted_d && o_perf_abort != '1) o_perf_abort <= o_perf_abort + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sng_scheduler.sv
// Bench for sng_scheduler: vector table, reset/round-robin sequences, random streams vs model.
module tb_sng_scheduler;
  import sng_sched_pkg::*;

  localparam int NB = 8;
  localparam int DM = 3;
  localparam int NR = 4;
  localparam int RW = 2;

  logic                          clk = 1'b0;
  logic                          rst = 1'b1;
  logic [NR-1:0]                 i_req = '0;
  logic [NR-1:0][DM-1:0][NB-1:0] i_x_bn;
  logic [NB-1:0]                 i_len = '0;
  logic                          i_abort = 1'b0;
  logic                          i_isgen = 1'b0;
  logic [NR-1:0]                 o_gnt, o_done;
  logic [RW-1:0]                 o_owner;
  logic                          o_busy, o_start, o_stop, o_aborted;
  logic [DM-1:0][NB-1:0]         o_x_bn;
  state_t                        o_state;
`ifdef SNG_SCHED_PERF_EN
  logic [31:0]                   o_perf_busy;
  logic [15:0]                   o_perf_abort;
`endif

  int total = 0;
  int bad   = 0;
  int gen_tail = 0;
  bit gen_quiet = 1'b0;

  always #5 clk = ~clk;

  sng_scheduler #(.NUM_BIT(NB), .DIM(DM), .NUM_REQ(NR), .REQ_W(RW)) dut (
    .i_clk_sng_sched (clk),
    .i_rst_sng_sched (rst),
    .i_req           (i_req),
    .i_x_bn          (i_x_bn),
    .i_len           (i_len),
    .i_abort         (i_abort),
    .o_gnt           (o_gnt),
    .o_owner         (o_owner),
    .o_busy          (o_busy),
    .o_x_bn          (o_x_bn),
    .o_start         (o_start),
    .o_stop          (o_stop),
    .i_isgen         (i_isgen),
    .o_done          (o_done),
    .o_aborted       (o_aborted),
`ifdef SNG_SCHED_PERF_EN
    .o_perf_busy     (o_perf_busy),
    .o_perf_abort    (o_perf_abort),
`endif
    .o_state         (o_state)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    total++;
    bad++;
    $display("FAIL %s: timed out waiting", name);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    i_abort = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  function automatic int oh2idx(input logic [NR-1:0] v);
    for (int i = 0; i < NR; i++) if (v[i]) return i;
    return -1;
  endfunction

  // Generator stand-in: active from o_start until a random 0..3 cycle tail after o_stop.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        i_isgen  = 1'b0;
        gen_tail = 0;
      end else if (o_start) begin
        if (!gen_quiet) i_isgen = 1'b1;
      end else if (o_stop) begin
        gen_tail = $urandom_range(0, 3);
        if (gen_tail == 0) i_isgen = 1'b0;
      end else if (gen_tail > 0) begin
        gen_tail--;
        if (gen_tail == 0) i_isgen = 1'b0;
      end
    end
  end

  // One full transaction; returns the granted index, start-to-stop distance and abort flag.
  task automatic run_one(input logic [NR-1:0] req, input logic [NB-1:0] len, input int abort_at,
                         input bit quiet, output int g_idx, output int delta, output logic ab);
    int                   n;
    int                   stops;
    logic [NR-1:0]        g;
    logic [DM-1:0][NB-1:0] exp_x;
    g_idx = -1;
    delta = -1;
    ab    = 1'bx;
    gen_quiet = quiet;
    i_req   = req;
    i_len   = len;
    i_abort = 1'b0;
    n = 0;
    while (o_gnt == '0 && n < 20) begin
      tick();
      n++;
    end
    if (o_gnt == '0) begin
      timeout("gnt_wait");
      return;
    end
    g     = o_gnt;
    g_idx = oh2idx(g);
    exp_x = i_x_bn[g_idx];
    check("gnt_onehot", 64'($onehot(g)), 64'd1);
    check("owner", 64'(o_owner), 64'(g_idx));
    check("busy_at_gnt", 64'(o_busy), 64'd1);
    check("x_bn_at_gnt", 64'(o_x_bn), 64'(exp_x));
    check("start_early", 64'(o_start), 64'd0);
    i_req = i_req & ~g;
    i_len = NB'($urandom);
    tick();
    check("start", 64'(o_start), 64'd1);
    check("gnt_pulse", 64'(o_gnt), 64'd0);
    i_abort = (abort_at == 0);
    delta = 0;
    while (delta < 300) begin
      tick();
      delta++;
      if (o_stop) break;
      i_abort = (delta == abort_at);
    end
    i_abort = 1'b0;
    if (!o_stop) begin
      timeout("stop_wait");
      return;
    end
    n = 0;
    stops = 0;
    while (o_done == '0 && n < 20) begin
      tick();
      n++;
      if (o_stop) stops++;
    end
    check("single_stop", 64'(stops), 64'd0);
    if (o_done == '0) begin
      timeout("done_wait");
      return;
    end
    check("done", 64'(o_done), 64'(g));
    check("busy_at_done", 64'(o_busy), 64'd1);
    check("x_bn_hold", 64'(o_x_bn), 64'(exp_x));
    ab = o_aborted;
    tick();
    check("busy_after_done", 64'(o_busy), 64'd0);
    check("done_pulse", 64'(o_done), 64'd0);
    check("no_gnt_after_done", 64'(o_gnt), 64'd0);
  endtask

  typedef struct {
    logic [NR-1:0] req;
    logic [NB-1:0] len;
    int            abort_at;
    bit            quiet;
    int            exp_owner;
    int            exp_delta;
    bit            exp_ab;
  } vec_t;

  vec_t tab [7];

  initial begin
    int            idx, d, best, model_ptr, len_e, ab_at;
    logic          ab;
    logic [NR-1:0] pending;
    bit            exp_ab;

    i_x_bn[0] = {8'h80, 8'h40, 8'hFF};
    i_x_bn[1] = {8'h11, 8'h22, 8'h33};
    i_x_bn[2] = {8'hA5, 8'h5A, 8'h0F};
    i_x_bn[3] = {8'h01, 8'hFE, 8'h7C};

    // Starting from rr_ptr=0 after reset; pointer walks 1,0,2,1,3,0,2.
    tab[0] = '{4'b0001, 8'd0, -1, 1'b0, 0, 255, 1'b0};
    tab[1] = '{4'b1000, 8'd1, -1, 1'b0, 3, 1,   1'b0};
    tab[2] = '{4'b1010, 8'd4, -1, 1'b1, 1, 4,   1'b0};
    tab[3] = '{4'b0011, 8'd3, -1, 1'b0, 0, 3,   1'b0};
    tab[4] = '{4'b0100, 8'd0, 10, 1'b0, 2, 11,  1'b1};
    tab[5] = '{4'b1001, 8'd5, 4,  1'b0, 3, 5,   1'b0};
    tab[6] = '{4'b0110, 8'd2, -1, 1'b0, 1, 2,   1'b0};

    #12;
    check("rst_busy", 64'(o_busy), 64'd0);
    check("rst_gnt", 64'(o_gnt), 64'd0);
    check("rst_state", 64'(o_state), 64'(IDLE));
    check("rst_x_bn", 64'(o_x_bn), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int v = 0; v < 7; v++) begin
      run_one(tab[v].req, tab[v].len, tab[v].abort_at, tab[v].quiet, idx, d, ab);
      check($sformatf("tab%0d_owner", v), 64'(idx), 64'(tab[v].exp_owner));
      check($sformatf("tab%0d_delta", v), 64'(d), 64'(tab[v].exp_delta));
      check($sformatf("tab%0d_aborted", v), 64'(ab), 64'(tab[v].exp_ab));
    end

    // Asynchronous reset in the middle of a long stream.
    i_req = 4'b0001;
    i_len = 8'd0;
    d = 0;
    while (!o_start && d < 10) begin
      tick();
      d++;
    end
    if (!o_start) timeout("rst_seq_start");
    i_req = '0;
    repeat (50) tick();
    check("pre_rst_busy", 64'(o_busy), 64'd1);
    i_req = 4'b0100;
    i_len = 8'd3;
    #2 rst = 1'b1;
    #1;
    check("arst_busy", 64'(o_busy), 64'd0);
    check("arst_state", 64'(o_state), 64'(IDLE));
    check("arst_outs", 64'({o_gnt, o_start, o_stop, o_done, o_aborted, o_owner}), 64'd0);
    check("arst_x_bn", 64'(o_x_bn), 64'd0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    check("arst_no_done", 64'(o_done), 64'd0);
    run_one(4'b0100, 8'd3, -1, 1'b0, idx, d, ab);
    check("arst_regrant", 64'(idx), 64'd2);
    check("arst_delta", 64'(d), 64'd3);

    // All four requesting continuously: strict rotation from 0.
    do_reset();
    for (int k = 0; k < 5; k++) begin
      run_one(4'b1111, 8'd4, -1, 1'b0, idx, d, ab);
      check($sformatf("rr%0d_owner", k), 64'(idx), 64'(k % NR));
      check($sformatf("rr%0d_delta", k), 64'(d), 64'd4);
      check($sformatf("rr%0d_aborted", k), 64'(ab), 64'd0);
    end

    // Random traffic against a pending-set / rotating-pointer model.
    do_reset();
    i_req = '0;
    model_ptr = 0;
    pending = '0;
    for (int t = 0; t < 40; t++) begin
      for (int r = 0; r < NR; r++) if (!pending[r]) i_x_bn[r] = (DM*NB)'($urandom);
      pending = pending | NR'($urandom_range(0, 15));
      if ($urandom_range(0, 4) == 0) pending[$urandom_range(0, NR-1)] = 1'b0;
      if (pending == '0) pending[$urandom_range(0, NR-1)] = 1'b1;
      len_e = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 12);
      ab_at = -1;
      if ($urandom_range(0, 3) == 0) ab_at = $urandom_range(0, (len_e == 0 ? 255 : len_e) + 1);
      best = -1;
      for (int s = 0; s < NR; s++) if (best < 0 && pending[(model_ptr + s) % NR]) best = (model_ptr + s) % NR;
      d = (len_e == 0) ? 255 : len_e;
      exp_ab = (ab_at >= 0) && (ab_at < d - 1);
      run_one(pending, NB'(len_e), ab_at, ($urandom_range(0, 4) == 0), idx, len_e, ab);
      check($sformatf("rnd%0d_owner", t), 64'(idx), 64'(best));
      check($sformatf("rnd%0d_delta", t), 64'(len_e), 64'(exp_ab ? ab_at + 1 : d));
      check($sformatf("rnd%0d_aborted", t), 64'(ab), 64'(exp_ab));
      model_ptr = (best + 1) % NR;
      pending[best] = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
